ms_delay_timer: RTL

Consumer of the 1 ms tick generator. Loads a duration in milliseconds, gates the tick generator on through msEnable, counts msTick pulses down to zero and issues a one-cycle done pulse. The memory-game sequencer uses it for LED-on, gap and response-timeout intervals.

---
 rtl/ms_delay_timer_pkg.sv | 13 +
 rtl/ms_delay_timer.sv | 90 +++++++++
 2 files changed

// File: rtl/ms_delay_timer_pkg.sv
// Shared state encodings and defaults for the millisecond delay timer.
// Imported by the timer and by any parent that decodes its state.
package ms_delay_timer_pkg;

   localparam int DEFAULT_WIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/ms_delay_timer.sv
// Millisecond interval timer: gates the 1 ms tick generator on while running,
// counts ticks down from the loaded duration and pulses done on expiry.
module ms_delay_timer
   import ms_delay_timer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             msTick,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] duration,
   output logic             msEnable,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] remaining
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [WIDTH-1:0] remaining_q, remaining_d;
   logic             ms_enable_q;
   logic             busy_q;
   logic             done_q;

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      case (state_q)
         ST_IDLE: begin
            remaining_d = '0;
            if (start && !abort) begin
               if (duration != '0) begin
                  state_d     = ST_RUN;
                  remaining_d = duration;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_RUN: begin
            // abort is checked first so a coincident tick cannot complete the interval
            if (abort) begin
               state_d     = ST_IDLE;
               remaining_d = '0;
            end else if (msTick) begin
               if (remaining_q > ONE) begin
                  remaining_d = remaining_q - ONE;
               end else begin
                  remaining_d = '0;
                  state_d     = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d     = ST_IDLE;
            remaining_d = '0;
         end
         default: begin
            state_d     = ST_IDLE;
            remaining_d = '0;
         end
      endcase
   end

   // Status outputs are decoded from the next state so they line up with state_q.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         ms_enable_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         ms_enable_q <= (state_d == ST_RUN);
         busy_q      <= (state_d != ST_IDLE);
         done_q      <= (state_d == ST_DONE);
      end
   end

   assign msEnable  = ms_enable_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign remaining = remaining_q;

endmodule
